scaler_cfg_ctrl: RTL
====================

# scaler_cfg_ctrl

Frame-safe configuration controller for the RGB bilinear scaler. It accepts target-resolution requests from the UART command decoder and range-checks them. Accepted values are held pending and only reach the scaler's `c_dst_img_width` / `c_dst_img_height` inputs at an end-of-frame boundary, so a frame is never scaled with mixed dimensions. A watchdog forces the update when no video is arriving.

## Interface
Parameters:
- `DEF_W`, 12'd1920: `c_dst_img_width` value after reset.
- `DEF_H`, 12'd1080: `c_dst_img_height` value after reset.
- `MIN_W` / `MAX_W`, 12'd64 / 12'd2560: inclusive width limits.
- `MIN_H` / `MAX_H`, 12'd48 / 12'd1440: inclusive height limits.
- `TIMEOUT_CYC`, 24'd3_000_000: cycles in WAIT_BLANK without a frame end before the update is forced.

Ports:
- `clk_in1`  in  1: the block's only clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: new resolution request.
- `req_width`  in  12: requested width.
- `req_height`  in  12: requested height.
- `req_ready`  out  1: request can be accepted this cycle.
- `per_img_vsync`  in  1: scaler input vsync, synchronous to `clk_in1`, high during an active frame.
- `c_dst_img_width`  out  12: applied width, drives the scaler.
- `c_dst_img_height`  out  12: applied height, drives the scaler.
- `cfg_done`  out  1: 1-cycle pulse when a new configuration is applied.
- `cfg_err`  out  1: 1-cycle pulse when a request is rejected.
- `cfg_timeout`  out  1: 1-cycle pulse when an apply was forced by the watchdog; asserted together with `cfg_done`.
- `cfg_busy`  out  1: a pending configuration exists (state is WAIT_BLANK).
- `apply_cnt`  out  8: number of applied configurations; wraps 255→0.

## Operation
- States: IDLE and WAIT_BLANK.
- Registers: pending width/height, `vsync_d`, 24-bit watchdog counter, `apply_cnt`.
- Frame end (`fe`): `vsync_d & ~per_img_vsync`.
- `req_ready`: combinational, equal to 1 in both states. It is 0 only while `rst` is high.
- Accept: `req_valid & req_ready`. The range check is combinational on the request inputs: `MIN_W ≤ req_width ≤ MAX_W` and `MIN_H ≤ req_height ≤ MAX_H`.
- IDLE, valid accept:
  - latch the request into the pending registers;
  - clear the watchdog;
  - go to WAIT_BLANK.
- IDLE, invalid accept: pulse `cfg_err`, stay in IDLE.
- WAIT_BLANK, valid accept: overwrite pending (latest request wins) and clear the watchdog.
- WAIT_BLANK, invalid accept: pulse `cfg_err`; the pending values and the watchdog are unchanged.
- WAIT_BLANK, `fe`, or watchdog count reaching `TIMEOUT_CYC-1`:
  - copy pending to `c_dst_img_*`;
  - pulse `cfg_done`;
  - increment `apply_cnt`;
  - go to IDLE.
  - On a watchdog apply, also pulse `cfg_timeout`.
- Simultaneous apply event and accepted request in WAIT_BLANK:
  - the apply uses the pending values from before this cycle;
  - a valid new request is latched as pending and the state stays WAIT_BLANK with the watchdog cleared;
  - an invalid new request pulses `cfg_err` and the state goes to IDLE.
- A request equal to the current `c_dst_img_*` is handled like any other valid request. It is applied at the next frame end and pulses `cfg_done`.
- A frame end in IDLE has no effect.
- Watchdog:
  - increments only in WAIT_BLANK;
  - saturates rather than wraps;
  - is cleared on entering IDLE.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - state IDLE;
  - `c_dst_img_width = DEF_W`, `c_dst_img_height = DEF_H`;
  - `cfg_done`, `cfg_err`, `cfg_timeout`, `cfg_busy` = 0;
  - `apply_cnt = 0`, `vsync_d = 0`, watchdog = 0, pending = DEF_W/DEF_H.
- `rst` takes effect mid-WAIT_BLANK: the pending configuration is discarded and nothing is applied.
- All outputs except `req_ready` are registered.
- Request accepted at cycle N:
  - `cfg_err` or `cfg_busy` changes at N+1.
- Falling vsync at sample cycle M (`vsync_d=1`, `per_img_vsync=0`):
  - `c_dst_img_*`, `cfg_done` and `apply_cnt` update at M+1;
  - `cfg_busy` drops at M+1.
- Watchdog apply: occurs `TIMEOUT_CYC` cycles after entering WAIT_BLANK or after the last valid overwrite.
- Minimum spacing between two applies: 2 cycles.
- Back-to-back requests are accepted every cycle.

## Test plan
- Reset, then idle 10 cycles.
  - Expect `c_dst` = 1920×1080, `apply_cnt` = 0, all pulses low, `req_ready` = 1.
- Request 1280×720 at cycle 5 while vsync is high; vsync falls at cycle 40.
  - `cfg_busy` = 1 from cycle 6.
  - `c_dst` = 1280×720 and `cfg_done` pulse at cycle 41.
  - `apply_cnt` = 1; `cfg_busy` = 0.
- Request 4000×720, then 64×47.
  - Each gives a `cfg_err` pulse one cycle after it.
  - `c_dst` unchanged; state stays IDLE; `cfg_busy` = 0.
- Request 800×600, then 1024×768 before the frame end.
  - The next frame end applies 1024×768.
  - Exactly one `cfg_done` pulse.
- With `TIMEOUT_CYC` = 100 and vsync held low, request 640×480 at cycle 0.
  - Apply with both `cfg_done` and `cfg_timeout` at cycle 101.
- Request 720×576 and a vsync fall in the same cycle while 800×600 is pending.
  - 800×600 is applied.
  - 720×576 stays pending (`cfg_busy` = 1) and is applied at the following frame end.
  - 256 applies in total take `apply_cnt` back to 0.

Source files
------------

// File: rtl/scaler_cfg_ctrl.sv
// scaler_cfg_ctrl: range-checks resolution requests and applies them to the scaler at frame end or on watchdog timeout
module scaler_cfg_ctrl #(
  parameter logic [11:0] DEF_W       = 12'd1920,
  parameter logic [11:0] DEF_H       = 12'd1080,
  parameter logic [11:0] MIN_W       = 12'd64,
  parameter logic [11:0] MAX_W       = 12'd2560,
  parameter logic [11:0] MIN_H       = 12'd48,
  parameter logic [11:0] MAX_H       = 12'd1440,
  parameter logic [23:0] TIMEOUT_CYC = 24'd3_000_000
) (
  input  logic        clk_in1,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [11:0] req_width,
  input  logic [11:0] req_height,
  output logic        req_ready,
  input  logic        per_img_vsync,
  output logic [11:0] c_dst_img_width,
  output logic [11:0] c_dst_img_height,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        cfg_timeout,
  output logic        cfg_busy,
  output logic [7:0]  apply_cnt
);
  typedef enum logic {IDLE, WAIT_BLANK} state_t;
  state_t      state_q, state_d;
  logic [11:0] pend_w_q, pend_w_d, pend_h_q, pend_h_d, dst_w_q, dst_w_d, dst_h_q, dst_h_d;
  logic [23:0] wd_q, wd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        vsync_d_q, done_q, done_d, err_q, err_d, to_q, to_d;
  logic        fe, wd_hit, apply, in_range, acc_ok;
  assign req_ready        = ~rst;
  assign c_dst_img_width  = dst_w_q;
  assign c_dst_img_height = dst_h_q;
  assign cfg_done         = done_q;
  assign cfg_err          = err_q;
  assign cfg_timeout      = to_q;
  assign cfg_busy         = state_q == WAIT_BLANK;
  assign apply_cnt        = cnt_q;
  always_comb begin
    fe       = vsync_d_q & ~per_img_vsync;
    wd_hit   = wd_q == TIMEOUT_CYC - 24'd1;
    apply    = (state_q == WAIT_BLANK) & (fe | wd_hit);
    in_range = req_width >= MIN_W && req_width <= MAX_W && req_height >= MIN_H && req_height <= MAX_H;
    acc_ok   = req_valid & req_ready & in_range;
    err_d    = req_valid & req_ready & ~in_range;
    state_d  = acc_ok ? WAIT_BLANK : (apply ? IDLE : state_q);
    pend_w_d = acc_ok ? req_width : pend_w_q;
    pend_h_d = acc_ok ? req_height : pend_h_q;
    wd_d     = (acc_ok || state_d == IDLE) ? 24'd0 : wd_q + 24'(wd_q != '1);
    dst_w_d  = apply ? pend_w_q : dst_w_q;
    dst_h_d  = apply ? pend_h_q : dst_h_q;
    done_d   = apply;
    to_d     = apply & ~fe;
    cnt_d    = cnt_q + 8'(apply);
  end
  always_ff @(posedge clk_in1) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_w_q  <= DEF_W;
      pend_h_q  <= DEF_H;
      dst_w_q   <= DEF_W;
      dst_h_q   <= DEF_H;
      wd_q      <= '0;
      cnt_q     <= '0;
      vsync_d_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_w_q  <= pend_w_d;
      pend_h_q  <= pend_h_d;
      dst_w_q   <= dst_w_d;
      dst_h_q   <= dst_h_d;
      wd_q      <= wd_d;
      cnt_q     <= cnt_d;
      vsync_d_q <= per_img_vsync;
      done_q    <= done_d;
      err_q     <= err_d;
      to_q      <= to_d;
    end
  end
endmodule
